// File: rtl/trng_pkg.sv
// Shared constants for the RNG consumer path: default widths, FSM state
// encodings and the von Neumann pair codes.
package trng_pkg;

  // Default parameter values
  localparam int DEF_RAW_W      = 16;
  localparam int DEF_OUT_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_REP_LIMIT  = 8;

  // FSM state encoding (IDLE, SCAN, FAIL)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_FAIL = 2'd2;

  // Pair decode: {w[2i+1], w[2i]}; only unequal pairs carry a bit,
  // and the emitted bit equals the upper bit of the pair.
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  function automatic logic pair_emits(input logic [1:0] pair);
    return (pair == PAIR_ONE) || (pair == PAIR_ZERO);
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// Small synchronous FIFO holding packed output words. Storage is cleared on
// reset so the head reads zero while empty after reset.
module trng_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and fill level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vn_extractor.sv
// Consumer side of the ring-oscillator RNG: repetition-count health test,
// von Neumann debiasing (one pair per cycle), LSB-first packing into OUT_W
// words, and an output FIFO.
//
// Handshakes: a raw word transfers on a rising edge where raw_en and raw_rdy
// are both 1; an output word transfers on a rising edge where out_valid and
// out_ready are both 1. Neither valid depends combinationally on its ready.
module vn_extractor
  import trng_pkg::*;
#(
  parameter int RAW_W      = DEF_RAW_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RAW_W-1:0] raw_in,
  input  logic             raw_en,
  output logic             raw_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int NPAIR = RAW_W / 2;
  localparam int IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = $clog2(REP_LIMIT + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(NPAIR - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] REP_TRIP = RW'(REP_LIMIT);

  state_t           state;
  logic [RAW_W-1:0] word;
  logic [RAW_W-1:0] prev_word;
  logic [RW-1:0]    rep_cnt;
  logic [RW-1:0]    rep_next;
  logic             rep_trip;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] push_word;
  logic [1:0]       pair;
  logic             accept;
  logic             emit;
  logic             new_bit;
  logic             complete;
  logic             push;
  logic             push_ok;
  logic             stall;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign raw_rdy   = (state == ST_IDLE);
  assign accept    = raw_en && raw_rdy;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign pair      = word[{idx, 1'b0} +: 2];
  assign emit      = (state == ST_SCAN) && pair_emits(pair);
  assign new_bit   = pair[1];
  assign complete  = emit && (cnt == CNT_LAST);
  assign push_ok   = !fifo_full || pop;
  assign push      = complete && push_ok;
  assign stall     = complete && !push_ok;

  // Repetition count the incoming word would produce; a zero count marks the
  // first word after reset so it never matches the cleared previous word.
  always_comb begin
    rep_next = RW'(1);
    if ((rep_cnt != '0) && (raw_in == prev_word)) begin
      rep_next = rep_cnt + 1'b1;
    end
    rep_trip = (rep_next >= REP_TRIP);
  end

  // Completed word: accumulator with the final bit dropped into place
  always_comb begin
    push_word      = acc;
    push_word[cnt] = new_bit;
  end

  // Control FSM, health test, pair scanning and bit packing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      word        <= '0;
      prev_word   <= '0;
      rep_cnt     <= '0;
      idx         <= '0;
      cnt         <= '0;
      acc         <= '0;
      health_fail <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            prev_word <= raw_in;
            rep_cnt   <= rep_next;
            if (rep_trip) begin
              state       <= ST_FAIL;
              health_fail <= 1'b1;
            end else begin
              word  <= raw_in;
              idx   <= '0;
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          // On a stall everything holds and the same pair is retried.
          if (!stall) begin
            if (emit) begin
              acc[cnt] <= new_bit;
              cnt      <= complete ? '0 : cnt + 1'b1;
            end
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= ST_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_FAIL: begin
          state <= ST_FAIL;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  trng_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_vn_extractor.sv
// Bench for vn_extractor: driver tasks, a reference model feeding an expected
// queue, a monitor popping it on every output transfer, and a final report.
module tb_vn_extractor;

  localparam int RAW_W = 16;
  localparam int OUT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [RAW_W-1:0] raw_in;
  logic             raw_en;
  logic             raw_rdy;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             health_fail;

  int total;
  int bad;

  logic [OUT_W-1:0] exp_q[$];

  // reference model state
  logic [RAW_W-1:0] m_prev;
  int               m_rep;
  logic [OUT_W-1:0] m_acc;
  int               m_cnt;
  logic             m_fail;

  vn_extractor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .raw_en      (raw_en),
    .raw_rdy     (raw_rdy),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = '0;
    m_rep  = 0;
    m_acc  = '0;
    m_cnt  = 0;
    m_fail = 1'b0;
  endtask

  // Health test followed by von Neumann extraction of one accepted word
  task automatic model_accept(input logic [RAW_W-1:0] w);
    int  rep;
    logic [1:0] pr;
    rep = (m_rep != 0 && w == m_prev) ? m_rep + 1 : 1;
    m_prev = w;
    m_rep  = rep;
    if (rep >= 8) begin
      m_fail = 1'b1;
      return;
    end
    for (int i = 0; i < RAW_W / 2; i++) begin
      pr = {w[2*i+1], w[2*i]};
      if (pr == 2'b10 || pr == 2'b01) begin
        m_acc[m_cnt] = pr[1];
        m_cnt++;
        if (m_cnt == OUT_W) begin
          exp_q.push_back(m_acc);
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    raw_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Present a word and hold it until accepted; returns just after the accepting edge
  task automatic send_word(input logic [RAW_W-1:0] w);
    int n;
    @(posedge clk);
    #1;
    raw_in = w;
    raw_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!raw_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!raw_rdy) begin
      check("accept_timeout", 32'd0, 32'd1);
      raw_en = 1'b0;
      return;
    end
    model_accept(w);
    @(posedge clk);
    #1;
    raw_en = 1'b0;
  endtask

  // Count cycles with raw_rdy low after an accept
  task automatic count_scan(output int n);
    n = 0;
    @(negedge clk);
    while (!raw_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
  endtask

  // scoreboard: compare every output transfer against the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int  n;
    bit  send_done;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    raw_en    = 1'b0;
    raw_in    = '0;
    out_ready = 1'b0;
    model_reset();
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, raw_rdy}, 32'd1);
    check("rst_health", {31'd0, health_fail}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);

    // 16'hAAAA: 8 scan cycles then 8'hFF visible
    send_word(16'hAAAA);
    count_scan(n);
    check("aaaa_scan", n, 8);
    check("aaaa_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_drain("aaaa");

    // 16'h5555 -> 8'h00
    do_reset();
    out_ready = 1'b1;
    send_word(16'h5555);
    wait_drain("p5555");

    // 16'h9999 -> 8'hAA
    do_reset();
    send_word(16'h9999);
    wait_drain("p9999");

    // discard: all-equal pairs emit nothing
    do_reset();
    send_word(16'h0000);
    count_scan(n);
    check("disc0_scan", n, 8);
    check("disc0_cnt", {29'd0, dut.cnt}, m_cnt);
    send_word(16'hFFFF);
    count_scan(n);
    check("discf_scan", n, 8);
    check("discf_cnt", {29'd0, dut.cnt}, 32'd0);
    check("disc_valid", {31'd0, out_valid}, 32'd0);

    // carry-over of a partial accumulator across words
    do_reset();
    send_word(16'h0009);
    count_scan(n);
    check("carry_cnt2", {29'd0, dut.cnt}, 32'd2);
    send_word(16'h00AA);
    count_scan(n);
    check("carry_cnt6", {29'd0, dut.cnt}, 32'd6);
    check("carry_novalid", {31'd0, out_valid}, 32'd0);
    send_word(16'hAAAA);
    count_scan(n);
    check("carry_cnt_end", {29'd0, dut.cnt}, m_cnt);
    wait_drain("carry");

    // backpressure: 4 words fill the FIFO, the 5th stalls on its last pair
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(16'hAAAA);
    repeat (12) @(negedge clk);
    check("bp_rdy", {31'd0, raw_rdy}, 32'd0);
    check("bp_idx", {29'd0, dut.idx}, 32'd7);
    check("bp_qlen", exp_q.size(), 5);
    out_ready = 1'b1;
    wait_drain("bp");

    // health test: near-miss runs, then a real trip
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_word(16'h1234);
    send_word(16'h1235);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_word(16'h1234);
    @(negedge clk);
    check("hl_nofail", {31'd0, health_fail}, 32'd0);
    repeat (10) @(negedge clk);
    send_word(16'h1234);
    @(negedge clk);
    check("hl_fail", {31'd0, health_fail}, {31'd0, m_fail});
    check("hl_rdy", {31'd0, raw_rdy}, 32'd0);
    repeat (20) @(negedge clk);
    check("hl_rdy_hold", {31'd0, raw_rdy}, 32'd0);
    check("hl_fifo_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_drain("hl");
    check("hl_sticky", {31'd0, health_fail}, 32'd1);

    // reset in the middle of a scan with two words queued
    do_reset();
    out_ready = 1'b0;
    send_word(16'hAAAA);
    send_word(16'hAAAA);
    send_word(16'hAAAA);
    repeat (3) @(posedge clk);
    #1;
    check("mr_idx", {29'd0, dut.idx}, 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_rdy", {31'd0, raw_rdy}, 32'd1);
    check("mr_health", {31'd0, health_fail}, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    send_word(16'hAAAA);
    check("mr_qlen", exp_q.size(), 1);
    wait_drain("mr");

    // random words under random backpressure
    do_reset();
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_word(16'($urandom_range(0, 65535)));
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("rnd");
    check("rnd_health", {31'd0, health_fail}, {31'd0, m_fail});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vn_extractor.md
# vn_extractor

Consumer side of the 16-bit ring-oscillator RNG: accepts raw RNG words, runs a repetition-count health test on them, removes bias with a von Neumann extractor (one bit pair per cycle), and packs the surviving bits into OUT_W-bit words. Packed words sit in a small FIFO and leave through a valid/ready port. The block sits between the RNG's registered `Out` bus and any downstream key or nonce consumer.

## Interface
- RAW_W, 16: raw word width; must be even.
- OUT_W, 8: packed output word width.
- FIFO_DEPTH, 4: number of output FIFO entries; must be a power of 2.
- REP_LIMIT, 8: number of consecutive identical accepted raw words that trips the health failure.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- raw_in  in  RAW_W  raw RNG word.
- raw_en  in  1  raw_in is valid this cycle.
- raw_rdy  out  1  block can accept a word this cycle.
- out_data  out  OUT_W  FIFO head.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  downstream accepts out_data.
- health_fail  out  1  sticky health-test failure.

## Operation
- States: IDLE, SCAN, FAIL. Reset enters IDLE.
- raw_rdy is 1 exactly when the state is IDLE. It is a combinational decode of the state.
- Accept happens when raw_en and raw_rdy are both 1.
- On accept, compare raw_in with the previous accepted word:
  - Equal: rep_cnt increments. Not equal, or first word after reset: rep_cnt = 1.
  - If the new rep_cnt would reach REP_LIMIT: go to FAIL, set health_fail, discard the word.
  - Otherwise: latch the word, set idx = 0, go to SCAN.
- Each SCAN cycle evaluates pair idx, where pair = {w[2·idx+1], w[2·idx]}:
  - "10" emits bit 1.
  - "01" emits bit 0.
  - "00" and "11" emit nothing.
- An emitted bit is written to acc[cnt], then cnt increments. Packing is LSB-first.
- When cnt = OUT_W-1 and a bit is emitted, the word is complete:
  - acc plus the new bit is pushed to the FIFO and cnt wraps to 0.
  - The push is allowed if the FIFO is not full, or if it is full and being popped this same cycle.
  - Otherwise the block stalls: idx, cnt and acc hold, and the pair is re-evaluated the next cycle.
- After pair RAW_W/2-1 is processed, the state returns to IDLE.
- A partial accumulator carries across raw words.
- FAIL is terminal until rst_n = 0. In FAIL:
  - raw_rdy = 0 and no new bits are produced.
  - The FIFO keeps draining.
- FIFO: pop when out_valid and out_ready are both 1. Simultaneous push and pop leaves the level unchanged.

## Timing
- Reset values: state = IDLE, raw_rdy = 1 from the first cycle after reset, out_valid = 0, out_data = 0 (FIFO storage is cleared), health_fail = 0, cnt = 0, idx = 0, rep_cnt = 0, previous-word register = 0.
- Throughput: at best one raw word per RAW_W/2+1 cycles (one IDLE cycle plus RAW_W/2 SCAN cycles).
- Latency: a word completed in SCAN cycle t shows out_valid = 1 in cycle t+1 when the FIFO was empty.
- health_fail rises in the cycle after the failing accept.
- Reset asserted mid-SCAN or mid-stall discards the partial accumulator and the FIFO contents.

## Structure
- Package trng_pkg holds:
  - the state enum (IDLE, SCAN, FAIL);
  - the default parameter constants;
  - the pair-decode localparams.
- Sub-module trng_fifo: synchronous FIFO with push, pop, full, empty and head data outputs, reset to empty with zeroed storage. vn_extractor instantiates it once.

## Test plan
- Bias patterns, each word accepted after reset:
  - raw_in = 16'hAAAA: 8 SCAN cycles, then out_data = 8'hFF with out_valid = 1.
  - raw_in = 16'h5555: out_data = 8'h00.
  - raw_in = 16'h9999: out_data = 8'hAA.
- Discard: send 16'h0000 then 16'hFFFF, out_ready = 1 → out_valid never rises and cnt stays 0; raw_rdy returns to 1 after each 8-cycle scan.
- Carry-over: send 16'h0009, then 16'h00AA. The first word yields only "0,1" (cnt = 2); the second yields four 1s (cnt = 6); no output yet. Then send 16'hAAAA → its first 2 bits complete the byte 8'hFE, and the remaining 6 bits leave cnt = 6.
- Backpressure: hold out_ready = 0 and send 5 words of 16'hAAAA.
  - Required: FIFO holds 4 × 8'hFF; the 5th scan stalls at idx = 7 with raw_rdy = 0.
  - Release with out_ready = 1 → 5 × 8'hFF delivered, none lost.
- Health test:
  - 7 × 16'h1234, then 16'h1235, then 7 × 16'h1234 → health_fail stays 0.
  - Follow with an 8th consecutive 16'h1234 → health_fail = 1 in the next cycle and raw_rdy stays 0.
  - FIFO contents still drain under out_ready = 1.
- Reset mid-operation: assert rst_n = 0 at idx = 3 of a 16'hAAAA scan with 2 words already in the FIFO → the next cycle shows out_valid = 0, raw_rdy = 1, health_fail = 0. A following 16'hAAAA yields exactly one 8'hFF.
